// File: rtl/nibble_serial_add_ctrl_if.sv
// Bundle of request, shared-slice and result signals for nibble_serial_add_ctrl.
// The out_ovf member exists only when ADDER_OVERFLOW_FLAG_EN is defined.
interface nibble_serial_add_ctrl_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_sub;
   logic [3:0]       slice_a;
   logic [3:0]       slice_b;
   logic             slice_cin;
   logic [3:0]       slice_r;
   logic             slice_cout;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
`ifdef ADDER_OVERFLOW_FLAG_EN
   logic             out_ovf;
`endif

   modport slave (
      input  in_valid, in_a, in_b, in_sub, slice_r, slice_cout, out_ready,
      output in_ready, slice_a, slice_b, slice_cin, out_valid, out_sum, out_cout
`ifdef ADDER_OVERFLOW_FLAG_EN
      , output out_ovf
`endif
   );

   modport master (
      output in_valid, in_a, in_b, in_sub, slice_r, slice_cout, out_ready,
      input  in_ready, slice_a, slice_b, slice_cin, out_valid, out_sum, out_cout
`ifdef ADDER_OVERFLOW_FLAG_EN
      , input out_ovf
`endif
   );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit add/sub sequencer reusing one external 4-bit adder slice, LSB nibble first.
// Defining ADDER_OVERFLOW_FLAG_EN adds the registered signed-overflow output out_ovf.
module nibble_serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   nibble_serial_add_ctrl_if.slave bus
);
   localparam int NIB = WIDTH / 4;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [IDXW-1:0]  idx_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] sum_r;
   logic             sub_r;
   logic             carry_r;
   logic             cout_r;
   logic             accept_s;
   logic             last_s;
   logic             in_ready_s;
   logic             out_valid_s;
   logic [3:0]       slice_a_s;
   logic [3:0]       slice_b_s;
   logic             slice_cin_s;

   assign accept_s = bus.in_valid && in_ready_s;
   assign last_s   = (state_r == RUN) && (idx_r == LAST_IDX);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_nxt_s = RUN;
            else          state_nxt_s = IDLE;
         end
         RUN: begin
            if (last_s) state_nxt_s = DONE;
            else        state_nxt_s = RUN;
         end
         DONE: begin
            if (bus.out_ready) state_nxt_s = IDLE;
            else               state_nxt_s = DONE;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output decode; the slice sees zeros whenever no nibble is in progress
   always_comb begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      slice_a_s   = 4'h0;
      slice_b_s   = 4'h0;
      slice_cin_s = 1'b0;
      case (state_r)
         IDLE: begin
            in_ready_s = 1'b1;
         end
         RUN: begin
            slice_a_s   = a_r[{idx_r, 2'b00} +: 4];
            slice_b_s   = b_r[{idx_r, 2'b00} +: 4] ^ {4{sub_r}};
            if (idx_r == '0) slice_cin_s = sub_r;
            else             slice_cin_s = carry_r;
         end
         DONE: begin
            out_valid_s = 1'b1;
         end
         default: begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
         end
      endcase
   end

   // Operand capture, nibble stepping and result accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r     <= '0;
         b_r     <= '0;
         sub_r   <= 1'b0;
         idx_r   <= '0;
         carry_r <= 1'b0;
         sum_r   <= '0;
         cout_r  <= 1'b0;
      end else if (accept_s) begin
         a_r     <= bus.in_a;
         b_r     <= bus.in_b;
         sub_r   <= bus.in_sub;
         idx_r   <= '0;
         carry_r <= 1'b0;
         sum_r   <= '0;
      end else if (state_r == RUN) begin
         sum_r[{idx_r, 2'b00} +: 4] <= bus.slice_r;
         carry_r <= bus.slice_cout;
         if (last_s) begin
            idx_r  <= '0;
            cout_r <= bus.slice_cout;
         end else begin
            idx_r  <= idx_r + IDXW'(1);
         end
      end
   end

`ifdef ADDER_OVERFLOW_FLAG_EN
   logic ovf_r;

   // Signed overflow: operand signs agree but the result sign differs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if (last_s) begin
         ovf_r <= (a_r[WIDTH-1] == slice_b_s[3]) && (bus.slice_r[3] != a_r[WIDTH-1]);
      end
   end

   assign bus.out_ovf = ovf_r;
`endif

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.out_sum   = sum_r;
   assign bus.out_cout  = cout_r;
   assign bus.slice_a   = slice_a_s;
   assign bus.slice_b   = slice_b_s;
   assign bus.slice_cin = slice_cin_s;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl (WIDTH=16) with a behavioural 4-bit adder slice.
module tb_nibble_serial_add_ctrl;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   exp_t exp_q[$];

   nibble_serial_add_ctrl_if #(.WIDTH(16)) ifc ();

   nibble_serial_add_ctrl #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   assign {ifc.slice_cout, ifc.slice_r} = 5'(ifc.slice_a) + 5'(ifc.slice_b) + 5'(ifc.slice_cin);

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
      exp_t        e;
      logic [15:0] bb;
      logic [16:0] full;
      bb     = sub ? ~b : b;
      full   = {1'b0, a} + {1'b0, bb} + 17'(sub);
      e.sum  = full[15:0];
      e.cout = full[16];
      e.ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
      return e;
   endfunction

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input int hold, input logic [15:0] na, input logic [15:0] nb,
                         output logic [3:0] cin_v, output logic [3:0] b0);
      exp_t e;
      int   cyc;
      int   w;
      cin_v = 4'h0;
      b0    = 4'h0;
      w     = 0;
      @(negedge clk);
      while (!ifc.in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!ifc.in_ready) begin
         check_val("in_ready_wait", 32'(ifc.in_ready), 32'd1);
         return;
      end
      ifc.in_a     = a;
      ifc.in_b     = b;
      ifc.in_sub   = sub;
      ifc.in_valid = 1'b1;
      exp_q.push_back(model(a, b, sub));
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
      ifc.in_a     = 16'($urandom);
      ifc.in_b     = 16'($urandom);
      ifc.in_sub   = 1'($urandom);
      cyc = 0;
      @(negedge clk);
      while (!ifc.out_valid && cyc < 20) begin
         cin_v = {ifc.slice_cin, cin_v[3:1]};
         if (cyc == 0) b0 = ifc.slice_b;
         cyc++;
         @(negedge clk);
      end
      check_val("latency", 32'(cyc), 32'd4);
      if (!ifc.out_valid) return;
      if (exp_q.size() == 0) begin
         check_val("queue_empty", 32'd0, 32'd1);
         return;
      end
      e = exp_q.pop_front();
      check_val("sum", 32'(ifc.out_sum), 32'(e.sum));
      check_val("cout", 32'(ifc.out_cout), 32'(e.cout));
`ifdef ADDER_OVERFLOW_FLAG_EN
      check_val("ovf", 32'(ifc.out_ovf), 32'(e.ovf));
`endif
      check_val("done_in_ready", 32'(ifc.in_ready), 32'd0);
      for (int h = 0; h < hold; h++) begin
         ifc.in_valid = 1'b1;
         ifc.in_a     = na;
         ifc.in_b     = nb;
         ifc.in_sub   = 1'b0;
         @(negedge clk);
         check_val("hold_sum", 32'(ifc.out_sum), 32'(e.sum));
         check_val("hold_valid", 32'(ifc.out_valid), 32'd1);
         check_val("hold_in_ready", 32'(ifc.in_ready), 32'd0);
      end
      ifc.out_ready = 1'b1;
      @(posedge clk);
      #1;
      ifc.out_ready = 1'b0;
      ifc.in_valid  = 1'b0;
      @(negedge clk);
      check_val("idle_in_ready", 32'(ifc.in_ready), 32'd1);
      check_val("idle_out_valid", 32'(ifc.out_valid), 32'd0);
   endtask

   initial begin
      logic [3:0] cin_v;
      logic [3:0] b0;
      n_checks      = 0;
      n_errors      = 0;
      clk           = 1'b0;
      rst_n         = 1'b0;
      ifc.in_valid  = 1'b0;
      ifc.in_a      = 16'h0;
      ifc.in_b      = 16'h0;
      ifc.in_sub    = 1'b0;
      ifc.out_ready = 1'b0;
      #12;
      check_val("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      check_val("rst_out_sum", 32'(ifc.out_sum), 32'd0);
      check_val("rst_out_cout", 32'(ifc.out_cout), 32'd0);
      check_val("rst_slice_a", 32'(ifc.slice_a), 32'd0);
      check_val("rst_in_ready", 32'(ifc.in_ready), 32'd1);
      rst_n = 1'b1;

      run_op(16'h1234, 16'h0FFF, 1'b0, 0, 16'h0, 16'h0, cin_v, b0);
      check_val("cin_seq_add", 32'(cin_v), 32'(4'b1110));
      run_op(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0, 16'h0, cin_v, b0);
      check_val("cin_seq_carry", 32'(cin_v), 32'(4'b1110));
      run_op(16'h0005, 16'h0007, 1'b1, 0, 16'h0, 16'h0, cin_v, b0);
      check_val("sub_b_nib0", 32'(b0), 32'h8);
      check_val("sub_cin0", 32'(cin_v[0]), 32'd1);
      run_op(16'h0007, 16'h0005, 1'b1, 0, 16'h0, 16'h0, cin_v, b0);

      run_op(16'h0ABC, 16'h0111, 1'b0, 3, 16'h2000, 16'h0002, cin_v, b0);
      run_op(16'h2000, 16'h0002, 1'b0, 0, 16'h0, 16'h0, cin_v, b0);

      // Abort an operation while idx is 2
      @(negedge clk);
      ifc.in_a     = 16'h1234;
      ifc.in_b     = 16'h1111;
      ifc.in_sub   = 1'b0;
      ifc.in_valid = 1'b1;
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_val("mid_run_slice_a", 32'(ifc.slice_a), 32'h2);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_out_valid", 32'(ifc.out_valid), 32'd0);
      check_val("mid_rst_out_sum", 32'(ifc.out_sum), 32'd0);
      check_val("mid_rst_slice_a", 32'(ifc.slice_a), 32'd0);
      check_val("mid_rst_slice_b", 32'(ifc.slice_b), 32'd0);
      check_val("mid_rst_slice_cin", 32'(ifc.slice_cin), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("post_rst_in_ready", 32'(ifc.in_ready), 32'd1);
      run_op(16'h00FF, 16'h0001, 1'b0, 0, 16'h0, 16'h0, cin_v, b0);

`ifdef ADDER_OVERFLOW_FLAG_EN
      run_op(16'h7FFF, 16'h0001, 1'b0, 0, 16'h0, 16'h0, cin_v, b0);
      run_op(16'h8000, 16'h0001, 1'b1, 0, 16'h0, 16'h0, cin_v, b0);
      run_op(16'h0001, 16'h0001, 1'b0, 0, 16'h0, 16'h0, cin_v, b0);
`endif

      for (int k = 0; k < 6; k++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         logic        rs;
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom);
         run_op(ra, rb, rs, k % 2, 16'($urandom), 16'($urandom), cin_v, b0);
         check_val("rand_cin0", 32'(cin_v[0]), 32'(rs));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that reuses one external 4-bit full-adder slice (a, b, cin -> r, cout) to add or subtract WIDTH-bit operands, one nibble per cycle, LSB nibble first.
- Holds operands, the carry between nibbles and the partial result.
- valid/ready handshake on the request side and on the result side.
- Sits between the operand source and the shared adder slice, so wide adds cost one slice instead of WIDTH/4.

Parameters:
- WIDTH, 16, operand/result width. Must be a multiple of 4 and >= 4.
- NIB, WIDTH/4, derived nibble count. Not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  controller can accept a request.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  1 = A-B, 0 = A+B.
- slice_a  output  4  nibble of A driven to the slice.
- slice_b  output  4  nibble of B driven to the slice; inverted when subtracting.
- slice_cin  output  1  carry-in driven to the slice.
- slice_r  input  4  slice sum, combinational from the slice_* outputs.
- slice_cout  input  1  slice carry-out.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  result.
- out_cout  output  1  final carry out. For subtract, 1 means no borrow.

Behaviour:
- States: IDLE, RUN, DONE. Nibble index register idx has width max(1, $clog2(NIB)).
- Reset (rst_n low, async):
  - state=IDLE, idx=0, carry=0, out_sum=0, out_cout=0, out_valid=0.
  - Operand and sub registers are cleared.
  - All slice_* outputs are 0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a clock edge: register in_a, in_b, in_sub; set idx=0; clear the result register; go to RUN.
- RUN:
  - in_ready=0.
  - Combinationally:
    - slice_a = A[4*idx+3 : 4*idx].
    - slice_b = B nibble XOR {4{sub}}.
    - slice_cin = (idx==0) ? sub : carry.
  - At each edge: result nibble idx <= slice_r; carry <= slice_cout; idx++.
  - When idx==NIB-1 at the edge: out_cout <= slice_cout and go to DONE.
- DONE:
  - out_valid=1. out_sum and out_cout are registered and stable.
  - in_ready=0.
  - Slice outputs are 0 outside RUN.
  - On out_valid&&out_ready: go to IDLE.
- Latency: the request handshake at edge E0 gives out_valid high after edge E0+NIB. For WIDTH=4 this is one RUN cycle.
- Throughput: one operation per NIB+2 cycles with no backpressure. The return to IDLE costs one cycle; no request is accepted in the same cycle as a result handshake.
- Backpressure: out_ready low holds DONE indefinitely. Outputs do not change and in_valid is ignored.
- in_a/in_b/in_sub may change after acceptance without affecting the operation in flight.
- Reset mid-RUN or mid-DONE: the operation is discarded, outputs are cleared immediately, and the controller restarts in IDLE after release.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1.

Optional Feature:
- Macro ADDER_OVERFLOW_FLAG_EN.
- When defined, adds port out_ovf (output, 1): signed two's-complement overflow, registered with out_cout.
  - Computed on the last RUN cycle: ovf = (A[WIDTH-1] == slice_b[3]) && (slice_r[3] != A[WIDTH-1]).
  - Reset to 0 and stable in DONE.
- When undefined, the port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=16, add 0x1234+0x0FFF -> out_sum=0x2233, out_cout=0. out_valid first high 4 cycles after the accept edge. slice_cin sequence 0,1,1,1.
- Add 0xFFFF+0x0001 -> out_sum=0x0000, out_cout=1. The carry propagates through all four nibbles.
- Sub 0x0005-0x0007 -> out_sum=0xFFFE, out_cout=0. Sub 0x0007-0x0005 -> 0x0002, out_cout=1. slice_b nibble 0 = 0x8 on the first subtract.
- Hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands:
  - out_sum, out_valid and in_ready stay stable.
  - The new request is accepted only in IDLE, the cycle after the result handshake.
- Assert rst_n low mid-RUN at idx=2:
  - out_valid=0, out_sum=0, slice_* = 0 immediately.
  - After release in_ready=1, and a subsequent 0x00FF+0x0001 returns 0x0100.
- With ADDER_OVERFLOW_FLAG_EN:
  - 0x7FFF+0x0001 -> out_sum=0x8000, out_ovf=1.
  - 0x8000-0x0001 -> 0x7FFF, out_ovf=1.
  - 0x0001+0x0001 -> out_ovf=0.
